// File: rtl/relm_custom_mul.sv
// Sequential radix-4 multiplier for the ReLM custom-op datapath: 2*WD-bit product, 2 bits per step.
// Optional RELM_MUL_SIGNED_EN builds the abs/negate path for two's-complement operands.
module relm_custom_mul #(
  parameter int unsigned WD   = 32,
  parameter int unsigned WCNT = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_in,
  input  logic [WD-1:0] a_in,
  input  logic [WD-1:0] b_in,
  input  logic          signed_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [WD-1:0] lo_out,
  output logic [WD-1:0] hi_out
);

  localparam int unsigned WA = 2 * WD + 2;
  localparam logic [WCNT-1:0] CntLast = WCNT'(WD / 2 - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [WD+1:0]   m1_q, m3_q;
  logic [WA-1:0]   acc_q;
  logic [WCNT-1:0] cnt_q;
  logic            neg_q;

  logic [WD-1:0]   mag_a, mag_b;
  logic            neg_load;
  logic [WD+1:0]   m1_load, m3_load;
  logic [WD+1:0]   addend, upper;
  logic [WA-1:0]   acc_next;
  logic [2*WD-1:0] prod, result;

`ifdef RELM_MUL_SIGNED_EN
  logic sgn_a, sgn_b;

  always_comb begin
    sgn_a    = signed_in & a_in[WD-1];
    sgn_b    = signed_in & b_in[WD-1];
    // Negating the most-negative value wraps back to 2**(WD-1), which is its unsigned magnitude.
    mag_a    = sgn_a ? (~a_in + WD'(1)) : a_in;
    mag_b    = sgn_b ? (~b_in + WD'(1)) : b_in;
    neg_load = (sgn_a ^ sgn_b) & (|a_in) & (|b_in);
    result   = neg_q ? (~prod + (2 * WD)'(1)) : prod;
  end
`else
  logic unused_sig;

  always_comb begin
    mag_a    = a_in;
    mag_b    = b_in;
    neg_load = 1'b0;
    result   = prod;
  end

  assign unused_sig = signed_in ^ neg_q;
`endif

  always_comb begin
    m1_load = {2'b00, mag_a};
    m3_load = {2'b00, mag_a} + {1'b0, mag_a, 1'b0};
    unique case (acc_q[1:0])
      2'b00:   addend = '0;
      2'b01:   addend = m1_q;
      2'b10:   addend = {m1_q[WD:0], 1'b0};
      default: addend = m3_q;
    endcase
    upper    = acc_q[WA-1:WD] + addend;
    acc_next = {2'b00, upper, acc_q[WD-1:2]};
    prod     = acc_next[2*WD-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      lo_out   <= '0;
      hi_out   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      m1_q     <= '0;
      m3_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_in) begin
            state_q  <= StRun;
            busy_out <= 1'b1;
            m1_q     <= m1_load;
            m3_q     <= m3_load;
            acc_q    <= {{(WD + 2){1'b0}}, mag_b};
            cnt_q    <= CntLast;
            neg_q    <= neg_load;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          if (cnt_q == '0) begin
            // Last step: publish the finished product straight from the final sum.
            state_q  <= StDone;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            hi_out   <= result[2*WD-1:WD];
            lo_out   <= result[WD-1:0];
          end else begin
            cnt_q <= cnt_q - WCNT'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
